// File: rtl/sram_like_slave_if.sv
// Request/response bundle of the SRAM-like bus between an initiator and
// the memory responder.
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave.sv
// Word-addressed memory model answering SRAM-like bus requests in order
// after a fixed latency, with up to DEPTH outstanding requests and optional
// pseudo-random back-pressure on addr_ok.
module sram_like_slave #(
  parameter int unsigned MEM_AW    = 12,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_en,
  sram_like_slave_if.slave bus
);

  localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW         = PW + 1;
  localparam int unsigned MW         = 1 << MEM_AW;
  localparam logic [3:0]  TIMER_INIT = 4'(LATENCY - 1);

  logic [31:0]       r_mem   [MW];
  logic [31:0]       r_data  [DEPTH];
  logic [3:0]        r_timer [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [15:0]       r_lfsr;

  logic [MEM_AW-1:0] w_idx;
  logic [31:0]       w_rd_word;
  logic              w_full;
  logic              w_stall;
  logic              w_accept;
  logic              w_data_ok;
  logic              w_unused;

  assign w_idx     = bus.addr[MEM_AW+1:2];
  assign w_rd_word = r_mem[w_idx];
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_stall   = stall_en & (r_lfsr[1:0] == 2'b00);
  assign w_accept  = bus.req & ~w_full & ~w_stall & ~reset;
  assign w_data_ok = (r_count != '0) && (r_timer[r_head] == '0);

  assign bus.addr_ok = w_accept;
  assign bus.data_ok = w_data_ok;
  assign bus.rdata   = w_data_ok ? r_data[r_head] : '0;

  // Transfer size and the byte-offset / wrapped address bits carry no meaning here.
  assign w_unused = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

  // Byte-lane writes into the word array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && bus.wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response FIFO: capture read data at acceptance, age timers, retire the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_timer[PW'(i)] <= '0;
        r_data[PW'(i)]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_timer[PW'(i)] != '0) begin
          r_timer[PW'(i)] <= r_timer[PW'(i)] - 4'd1;
        end
      end
      // Later assignment overrides the aging of the slot being filled.
      if (w_accept) begin
        r_data[r_tail]  <= bus.wr ? '0 : w_rd_word;
        r_timer[r_tail] <= TIMER_INIT;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_data_ok) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_accept, w_data_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Fibonacci LFSR (taps 16,14,13,11) driving the optional addr_ok stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed self-checking bench for sram_like_slave using three instances
// at different latencies.
module tb_sram_like_slave;

  logic        clk;
  logic        reset;
  logic        stall_a;
  logic [15:0] m_lfsr;
  int          n_checks = 0;
  int          n_fail   = 0;

  sram_like_slave_if if_a ();
  sram_like_slave_if if_b ();
  sram_like_slave_if if_c ();

  sram_like_slave #(.LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .stall_en(stall_a), .bus(if_a)
  );
  sram_like_slave #(.LATENCY(8), .DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .stall_en(1'b0), .bus(if_b)
  );
  sram_like_slave #(.LATENCY(4)) u_c (
    .clk(clk), .reset(reset), .stall_en(1'b0), .bus(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference stall LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pre_val(input int unsigned k);
    return 32'h5000_0000 + k * 32'h0001_0101;
  endfunction

  function automatic logic [31:0] b_val(input int unsigned k);
    return 32'hB0B0_0000 + k;
  endfunction

  // One request on instance A (LATENCY 1, no stalls): accepted at once,
  // response in the cycle right after acceptance.
  task automatic a_op(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp, input string tag);
    @(negedge clk);
    if_a.req = 1'b1; if_a.wr = w; if_a.addr = ad; if_a.wdata = wd;
    if_a.wstrb = st; if_a.size = 2'b10;
    #1;
    chk1({tag, "_aok"}, if_a.addr_ok, 1'b1);
    @(posedge clk); #1;
    if_a.req = 1'b0;
    chk1({tag, "_dok"}, if_a.data_ok, 1'b1);
    chk({tag, "_rdata"}, if_a.rdata, exp);
    @(posedge clk); #1;
    chk1({tag, "_idle"}, if_a.data_ok, 1'b0);
  endtask

  // Write on instance B, waiting (bounded) for acceptance.
  task automatic b_wr(input logic [31:0] ad, input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    if_b.req = 1'b1; if_b.wr = 1'b1; if_b.addr = ad; if_b.wdata = wd;
    if_b.wstrb = 4'hF; if_b.size = 2'b10;
    #1;
    while (!if_b.addr_ok && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    chk1("b_wr_accept", if_b.addr_ok, 1'b1);
    @(posedge clk); #1;
    if_b.req = 1'b0;
  endtask

  initial begin
    int unsigned acc;
    int unsigned resp;
    int unsigned pulses;
    logic        exp_aok;
    logic        exp_dok;
    int unsigned k;

    reset   = 1'b1;
    stall_a = 1'b0;
    if_a.req = 1'b1; if_a.wr = 1'b0; if_a.size = '0; if_a.wstrb = '0; if_a.addr = '0; if_a.wdata = '0;
    if_b.req = 1'b0; if_b.wr = 1'b0; if_b.size = '0; if_b.wstrb = '0; if_b.addr = '0; if_b.wdata = '0;
    if_c.req = 1'b0; if_c.wr = 1'b0; if_c.size = '0; if_c.wstrb = '0; if_c.addr = '0; if_c.wdata = '0;

    // Reset state: request is ignored while reset is high.
    #12;
    chk1("rst_aok", if_a.addr_ok, 1'b0);
    chk1("rst_dok", if_a.data_ok, 1'b0);
    chk("rst_rdata", if_a.rdata, 32'h0);
    chk1("rst_b_dok", if_b.data_ok, 1'b0);
    chk1("rst_c_dok", if_c.data_ok, 1'b0);
    if_a.req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("post_rst_dok", if_a.data_ok, 1'b0);

    // Basic write then read.
    a_op(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, "wr40");
    a_op(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, "rd40");

    // Byte strobes.
    a_op(1'b1, 32'h80, 32'h11223344, 4'hF, 32'h0, "wr80a");
    a_op(1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, 32'h0, "wr80b");
    a_op(1'b0, 32'h80, 32'h0, 4'h0, 32'h11BB33DD, "rd80");

    // Address wrap: 0x4000 aliases word 0 with MEM_AW=12; ignores addr[1:0].
    a_op(1'b1, 32'h0000_4000, 32'hCAFE0001, 4'hF, 32'h0, "wrwrap");
    a_op(1'b0, 32'h0000_0003, 32'h0, 4'h0, 32'hCAFE0001, "rdwrap");
    a_op(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, "rd40again");

    // Preload 64 words for the stall run.
    for (int unsigned i = 0; i < 64; i++) begin
      a_op(1'b1, 32'h800 + 4 * i, pre_val(i), 4'hF, 32'h0, "pre");
    end

    // 64 back-to-back reads under pseudo-random back-pressure.
    stall_a = 1'b1;
    acc  = 0;
    resp = 0;
    for (int cyc = 0; cyc < 2000 && (acc < 64 || resp < 64); cyc++) begin
      @(negedge clk);
      if (acc < 64) begin
        if_a.req = 1'b1; if_a.wr = 1'b0; if_a.addr = 32'h800 + 4 * acc;
      end else begin
        if_a.req = 1'b0;
      end
      #1;
      chk1("stall_aok", if_a.addr_ok, (acc < 64) && (m_lfsr[1:0] != 2'b00));
      if (if_a.data_ok) begin
        chk("stall_rdata", if_a.rdata, pre_val(resp));
        resp++;
      end
      if (if_a.req && if_a.addr_ok) acc++;
    end
    if_a.req = 1'b0;
    stall_a  = 1'b0;
    chk("stall_accepts", 32'(acc), 32'd64);
    chk("stall_responses", 32'(resp), 32'd64);
    repeat (3) begin
      @(negedge clk); #1;
      chk1("stall_no_extra", if_a.data_ok, 1'b0);
    end

    // Full-FIFO back-pressure on instance B (LATENCY 8, DEPTH 4).
    for (int unsigned i = 0; i < 5; i++) b_wr(4 * i, b_val(i));
    repeat (12) @(negedge clk);
    #1;
    chk1("b_drained", if_b.data_ok, 1'b0);
    acc = 0;
    for (int unsigned j = 0; j < 19; j++) begin
      @(negedge clk);
      if (acc < 5) begin
        if_b.req = 1'b1; if_b.wr = 1'b0; if_b.addr = 4 * acc;
      end else begin
        if_b.req = 1'b0;
      end
      #1;
      exp_aok = (j < 4) || (j == 9);
      exp_dok = (j >= 8 && j <= 11) || (j == 17);
      chk1("full_aok", if_b.addr_ok, exp_aok);
      chk1("full_dok", if_b.data_ok, exp_dok);
      if (exp_dok) begin
        k = (j <= 11) ? j - 8 : 4;
        chk("full_rdata", if_b.rdata, b_val(k));
      end
      if (if_b.req && if_b.addr_ok) acc++;
    end
    chk("full_accepts", 32'(acc), 32'd5);

    // Reset with three reads outstanding on instance C (LATENCY 4).
    @(negedge clk);
    if_c.req = 1'b1; if_c.wr = 1'b1; if_c.addr = 32'h100; if_c.wdata = 32'h5A5A1234; if_c.wstrb = 4'hF;
    #1;
    chk1("c_wr_aok", if_c.addr_ok, 1'b1);
    @(posedge clk); #1;
    if_c.req = 1'b0;
    repeat (6) @(negedge clk);
    if_c.req = 1'b1; if_c.wr = 1'b0; if_c.addr = 32'h100;
    #1;
    chk1("c_rd0_aok", if_c.addr_ok, 1'b1);
    @(posedge clk); #1;
    if_c.addr = 32'h104;
    chk1("c_rd1_aok", if_c.addr_ok, 1'b1);
    @(posedge clk); #1;
    if_c.addr = 32'h108;
    chk1("c_rd2_aok", if_c.addr_ok, 1'b1);
    @(posedge clk); #1;
    if_c.req = 1'b0;
    chk1("c_pending_dok", if_c.data_ok, 1'b0);
    @(negedge clk); #1;
    reset    = 1'b1;
    if_c.req = 1'b1;
    #1;
    chk1("c_rst_dok", if_c.data_ok, 1'b0);
    chk("c_rst_rdata", if_c.rdata, 32'h0);
    chk1("c_rst_aok", if_c.addr_ok, 1'b0);
    if_c.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (if_c.data_ok) pulses++;
    end
    chk("c_dropped_pulses", 32'(pulses), 32'd0);

    // Memory survives reset; data_ok exactly LATENCY cycles later.
    @(negedge clk);
    if_c.req = 1'b1; if_c.wr = 1'b0; if_c.addr = 32'h100;
    #1;
    chk1("c_post_aok", if_c.addr_ok, 1'b1);
    @(posedge clk); #1;
    if_c.req = 1'b0;
    chk1("c_lat0_dok", if_c.data_ok, 1'b0);
    for (int unsigned i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk1("c_lat_dok", if_c.data_ok, i == 3);
    end
    chk("c_post_rdata", if_c.rdata, 32'h5A5A1234);

    // Asynchronous reset drops a live response immediately.
    #1;
    reset = 1'b1;
    #1;
    chk1("c_async_dok", if_c.data_ok, 1'b0);
    chk("c_async_rdata", if_c.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
Responder end of the SRAM-like request/response bus driven by the instruction and data fetch front ends (req/wr/size/wstrb/addr/wdata out; addr_ok/data_ok/rdata back). It is a word-addressed memory model that accepts requests and returns in-order responses after a fixed latency, with up to DEPTH requests outstanding. Optional pseudo-random addr_ok back-pressure exercises initiator stall and discard paths. It is used as the simulation and FPGA-bring-up memory behind the core.

Parameters:
MEM_AW, 12, log2 of memory size in 32-bit words; word index is addr[MEM_AW+1:2].
LATENCY, 1, cycles from the acceptance edge to data_ok; legal range 1..15.
DEPTH, 4, maximum outstanding accepted-but-unanswered requests; power of 2, at least 2.
LFSR_SEED, 16'hACE1, reset value of the stall LFSR; must be nonzero.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
stall_en  in  1  enables pseudo-random addr_ok back-pressure
req  in  1  request valid; initiator holds it and all request fields stable until addr_ok
wr  in  1  1 = write, 0 = read
size  in  2  transfer size; recorded only, not used for lane selection
wstrb  in  4  write byte enables; bit i enables byte lane i
addr  in  32  byte address
wdata  in  32  write data
addr_ok  out  1  request accepted this cycle
data_ok  out  1  response valid this cycle
rdata  out  32  read data; valid only while data_ok is high

Behaviour:
- Handshake: a request is accepted at a rising edge when req and addr_ok are both high. addr_ok = req & !full & !stall_now & !reset, combinational.
- full means count == DEPTH. A request is not accepted while full, even in a cycle where the head entry retires.
- stall_now = stall_en & (lfsr[1:0] == 2'b00). The LFSR is 16-bit Fibonacci with taps 16,14,13,11, advances every cycle, and resets to LFSR_SEED.
- Write acceptance: at the acceptance edge, mem[idx] is updated on each byte lane whose wstrb bit is set. The response entry gets rdata = 0.
- Read acceptance: at the acceptance edge, mem[idx] is sampled into the response entry. The sample reflects all writes accepted at earlier edges.
- Addressing: addr[1:0] is ignored. Address bits above MEM_AW+1 are ignored, so addresses wrap within the memory.
- Response FIFO: DEPTH entries, each holding {data, timer}. The timer loads LATENCY-1 at acceptance and decrements each cycle, saturating at 0.
- Response timing: data_ok = head valid & head timer == 0, combinational, and rdata = head data. A request accepted at edge t has data_ok high in the cycle following edge t+LATENCY-1. With LATENCY = 1, that is the cycle right after acceptance.
- Retirement: the head pops at the edge ending any cycle in which data_ok is high. There is no response back-pressure: the initiator must take data_ok unconditionally and discard unwanted data itself.
- Ordering: responses come strictly in acceptance order, at most one per cycle. Back-to-back acceptances give back-to-back data_ok cycles.
- Counting: count increments on accept, decrements on pop, and is unchanged when both happen in the same cycle.
- Empty FIFO: data_ok = 0 and rdata = 32'h0.
- Reset (asynchronous, any time, including mid-burst):
  - FIFO empty, count = 0, all timers 0.
  - data_ok = 0, rdata = 0, addr_ok = 0, lfsr = LFSR_SEED.
  - Outstanding requests are dropped with no response.
  - Memory contents are NOT reset.
- Invariant: the number of data_ok pulses since reset never exceeds the number of accepted requests.

Test Plan:
- LATENCY=1, stall_en=0: write 32'hDEADBEEF, wstrb=4'hF, to addr 32'h40; then read 32'h40. Each addr_ok is high in the same cycle req rises; the read's data_ok appears 1 cycle later with rdata = 32'hDEADBEEF.
- Byte strobes: write 32'h11223344 (wstrb 4'hF) to 32'h80, then 32'hAABBCCDD with wstrb 4'b0101, then read. rdata = 32'h11BB33DD.
- DEPTH=4, LATENCY=8, req held high: addresses 0, 4, 8, 12, 16 presented. Four accepts occur, then addr_ok stays 0 until the first data_ok retires. The 5th request is accepted the cycle after that retirement, and data returns in order.
- stall_en=1, 64 back-to-back reads: total accepts = 64 and data_ok pulses = 64, in order. addr_ok is low exactly in the cycles where lfsr[1:0] == 0, and no request is lost or duplicated.
- Reset mid-operation: LATENCY=4, assert reset 2 cycles after 3 accepts. data_ok drops immediately, no response for those 3 is ever produced, and reading a previously written address after reset returns the old data.
- Wrap-around: MEM_AW=12, write 32'hCAFE0001 to 32'h0000_4000, then read 32'h0. rdata = 32'hCAFE0001.
